// File: rtl/layer3_weight_sched.sv
`default_nettype none
// ============================================================================
//  Module      : layer3_weight_sched
//  Description : Splits one shared weight stream into three per-convolution
//                weight streams (conv1, conv2, conv3) in a fixed order.
//                Each accepted word is forwarded to the output of the stage
//                that was active when it arrived, one cycle later.
//                Optional macro LAYER3_WSCHED_ERR_EN enables a sticky flag
//                for words offered while the block is not ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer3_weight_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int W1_COUNT   = 262144,
    parameter int W2_COUNT   = 589824,
    parameter int W3_COUNT   = 262144
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  w_valid_in,
    input  logic [DATA_WIDTH-1:0] w_data_in,
    output logic                  w_ready,
    output logic                  valid_weight_out1,
    output logic                  valid_weight_out2,
    output logic                  valid_weight_out3,
    output logic [DATA_WIDTH-1:0] weight_out1,
    output logic [DATA_WIDTH-1:0] weight_out2,
    output logic [DATA_WIDTH-1:0] weight_out3,
    output logic [1:0]            stage,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // One shared counter sized for the largest stage; width kept >= 1 so a
    // degenerate all-ones configuration still yields a legal vector.
    localparam int c_MAX12 = (W1_COUNT > W2_COUNT) ? W1_COUNT : W2_COUNT;
    localparam int c_MAX   = (c_MAX12 > W3_COUNT) ? c_MAX12 : W3_COUNT;
    localparam int c_CW    = (c_MAX > 1) ? $clog2(c_MAX) : 1;

    localparam logic [c_CW-1:0] c_W1_LAST = c_CW'(W1_COUNT - 1);
    localparam logic [c_CW-1:0] c_W2_LAST = c_CW'(W2_COUNT - 1);
    localparam logic [c_CW-1:0] c_W3_LAST = c_CW'(W3_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD1 = 3'd1,
        S_LOAD2 = 3'd2,
        S_LOAD3 = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_last_idx;
    logic              w_accept;
    logic              w_at_last;

    logic                  r_vld1, r_vld2, r_vld3;
    logic [DATA_WIDTH-1:0] r_wout1, r_wout2, r_wout3;

    assign w_accept  = w_valid_in & w_ready;
    assign w_at_last = w_accept & (r_cnt == w_last_idx);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and state-decoded outputs (ready, stage, busy, done).
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        stage        = 2'd0;
        done         = 1'b0;
        w_last_idx   = c_W1_LAST;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_LOAD1;
                end
            end
            S_LOAD1: begin
                w_ready    = 1'b1;
                stage      = 2'd1;
                w_last_idx = c_W1_LAST;
                if (w_at_last) begin
                    w_next_state = S_LOAD2;
                end
            end
            S_LOAD2: begin
                w_ready    = 1'b1;
                stage      = 2'd2;
                w_last_idx = c_W2_LAST;
                if (w_at_last) begin
                    w_next_state = S_LOAD3;
                end
            end
            S_LOAD3: begin
                w_ready    = 1'b1;
                stage      = 2'd3;
                w_last_idx = c_W3_LAST;
                if (w_at_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign busy = (stage != 2'd0);

    // Word counter: wraps to zero on the last word of each stage, so every
    // stage (including LOAD1 after IDLE) starts counting from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_at_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Route accepted words to the active conv output one cycle later; data
    // registers only load on acceptance so they hold between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld1  <= 1'b0;
            r_vld2  <= 1'b0;
            r_vld3  <= 1'b0;
            r_wout1 <= '0;
            r_wout2 <= '0;
            r_wout3 <= '0;
        end else begin
            r_vld1 <= w_accept && (r_state == S_LOAD1);
            r_vld2 <= w_accept && (r_state == S_LOAD2);
            r_vld3 <= w_accept && (r_state == S_LOAD3);
            if (w_accept && (r_state == S_LOAD1)) begin
                r_wout1 <= w_data_in;
            end
            if (w_accept && (r_state == S_LOAD2)) begin
                r_wout2 <= w_data_in;
            end
            if (w_accept && (r_state == S_LOAD3)) begin
                r_wout3 <= w_data_in;
            end
        end
    end

    assign valid_weight_out1 = r_vld1;
    assign valid_weight_out2 = r_vld2;
    assign valid_weight_out3 = r_vld3;
    assign weight_out1       = r_wout1;
    assign weight_out2       = r_wout2;
    assign weight_out3       = r_wout3;

`ifdef LAYER3_WSCHED_ERR_EN
    logic r_err;

    // Sticky flag: a word offered while not ready is recorded until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_valid_in && !w_ready) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/layer3_weight_sched.md
LAYER3_WEIGHT_SCHED -- requirements
Module: layer3_weight_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of weight words.
REQ-002 SHALL have parameter W1_COUNT, default 262144, number of conv1 (1x1, 1024->256) weight words.
REQ-003 SHALL have parameter W2_COUNT, default 589824, number of conv2 (3x3, 256->256) weight words.
REQ-004 SHALL have parameter W3_COUNT, default 262144, number of conv3 (1x1, 256->1024) weight words.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  begin one weight-load sequence.
REQ-008 SHALL have port w_valid_in  input  1  weight word on w_data_in is valid.
REQ-009 SHALL have port w_data_in  input  DATA_WIDTH  shared weight stream.
REQ-010 SHALL have port w_ready  output  1  block accepts a word this cycle.
REQ-011 SHALL have ports valid_weight_out1/2/3  output  1 each  per-conv weight strobe.
REQ-012 SHALL have ports weight_out1/2/3  output  DATA_WIDTH each  per-conv weight word.
REQ-013 SHALL have port stage  output  2  0 idle, 1/2/3 loading conv1/2/3.
REQ-014 SHALL have port busy  output  1  high in any LOAD state.
REQ-015 SHALL have port done  output  1  one-cycle pulse at sequence end.
REQ-016 SHALL have port err  output  1  sticky stray-word flag (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, LOAD1, LOAD2, LOAD3, DONE.
REQ-018 IDLE -> LOAD1 SHALL occur on start=1; start in any other state SHALL be ignored.
REQ-019 w_ready SHALL be 1 in LOAD1/2/3 and 0 in IDLE/DONE (combinational from state).
REQ-020 A word SHALL be accepted when w_valid_in & w_ready; only accepted words advance the counter.
REQ-021 Accepted word SHALL appear on weight_outN with valid_weight_outN=1 exactly 1 cycle later, N = current stage; other valid_weight_out strobes SHALL be 0.
REQ-022 weight_outN SHALL hold last value when its strobe is low.
REQ-023 A single word counter, width clog2 of max(W1_COUNT,W2_COUNT,W3_COUNT), SHALL reset to 0 on every stage entry.
REQ-024 Accepting the word with counter = WN_COUNT-1 SHALL move to the next stage in the same edge; the next cycle's word goes to the next conv with no bubble.
REQ-025 Last word of LOAD3 SHALL move FSM to DONE; DONE SHALL last one cycle, assert done=1, then return to IDLE.
REQ-026 stage SHALL equal 1/2/3 in LOAD1/2/3 and 0 in IDLE/DONE; busy = (stage!=0).
REQ-027 W1_COUNT, W2_COUNT, W3_COUNT SHALL be >= 1; zero is illegal configuration.
REQ-028 w_valid_in gaps SHALL stall the sequence indefinitely without state change.

Reset
REQ-029 reset=1 SHALL force IDLE, counter 0, all valid_weight_out 0, weight_out 0, done 0, err 0, regardless of state.
REQ-030 reset mid-load SHALL abandon the sequence; no strobe SHALL be emitted in the cycle after reset asserted.
REQ-031 reset SHALL take priority over start and w_valid_in.

Configuration
REQ-032 Macro LAYER3_WSCHED_ERR_EN SHALL control stray-word detection.
REQ-033 With LAYER3_WSCHED_ERR_EN defined: w_valid_in=1 while w_ready=0 SHALL set err=1 the next cycle, held until reset.
REQ-034 Without it: err SHALL be tied 0 and stray words silently dropped; all other behaviour identical.

Verification (W1_COUNT=4, W2_COUNT=9, W3_COUNT=4, DATA_WIDTH=32)
REQ-035 Reset then start, 17 back-to-back words 1..17 -> out1 gets 1-4, out2 5-13, out3 14-17, each 1 cycle after input; done pulses once 1 cycle after word 17 accepted; w_ready low afterwards.
REQ-036 Same stream with w_valid_in toggling every other cycle -> identical per-conv sequences, no extra/missing strobes, stage transitions only on accepted words.
REQ-037 reset asserted after word 7 accepted -> next cycle all strobes 0, stage 0; new start + 17 words -> word 1 of new stream goes to out1.
REQ-038 start pulsed during LOAD2 -> no effect; sequence completes normally with 17 words.
REQ-039 With LAYER3_WSCHED_ERR_EN: w_valid_in=1 in IDLE -> err=1 next cycle, stays 1 through a full sequence; without macro -> err stays 0, no strobes.
REQ-040 start asserted in DONE cycle -> ignored; FSM returns IDLE, second start needed to load again.
